// File: rtl/pwm_capture_pkg.sv
// Shared constants and FSM state type for the servo pulse-width capture block.
package pwm_capture_pkg;

    localparam int unsigned CLK_PER_US = 100;
    localparam int unsigned MIN_US     = 800;
    localparam int unsigned MAX_US     = 2200;
    localparam int unsigned TIMEOUT_US = 25000;
    localparam int unsigned NEUTRAL_US = 1500;

    localparam int unsigned XVAL_W   = 11;
    localparam int unsigned PERIOD_W = 15;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser for the asynchronous pulse line followed by a registered
// edge detector producing single-cycle rise/fall strobes aligned with the level.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       meta_q;
    logic       sync_q;
    logic       level_q;
    logic       rise_q;
    logic       fall_q;
    logic [2:0] fill_q;

    // fill_q[2] marks that level_q holds a real sample, so a line that is already
    // high when reset releases never produces a rise strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fill_q  <= 3'b000;
        end else begin
            meta_q  <= pwm_in;
            sync_q  <= meta_q;
            level_q <= sync_q;
            fill_q  <= {fill_q[1:0], 1'b1};
            rise_q  <= fill_q[2] & sync_q & ~level_q;
            fall_q  <= fill_q[2] & ~sync_q & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures servo-style PWM high time in microseconds, validates it against the
// accepted range and flags loss of signal when rising edges stop arriving.
module pwm_capture #(
    parameter int unsigned CLK_PER_US = pwm_capture_pkg::CLK_PER_US,
    parameter int unsigned MIN_US     = pwm_capture_pkg::MIN_US,
    parameter int unsigned MAX_US     = pwm_capture_pkg::MAX_US,
    parameter int unsigned TIMEOUT_US = pwm_capture_pkg::TIMEOUT_US
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [10:0] x_val,
    output logic        valid,
    output logic        err,
    output logic        timeout
);

    import pwm_capture_pkg::state_e;
    import pwm_capture_pkg::StIdle;
    import pwm_capture_pkg::StHigh;
    import pwm_capture_pkg::StLow;
    import pwm_capture_pkg::NEUTRAL_US;
    import pwm_capture_pkg::XVAL_W;
    import pwm_capture_pkg::PERIOD_W;

    localparam int unsigned PSC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    logic line_level;
    logic rise;
    logic fall;

    pwm_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (line_level),
        .rise   (rise),
        .fall   (fall)
    );

    state_e              state_q, state_d;
    logic [PSC_W-1:0]    psc_q, psc_d;
    logic [XVAL_W-1:0]   width_q, width_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [XVAL_W-1:0]   x_val_q, x_val_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                timeout_q, timeout_d;

    logic                us_tick;
    logic                width_sat;
    logic [XVAL_W-1:0]   width_meas;
    logic                period_hit;
    logic                in_range;

    always_comb begin
        us_tick    = (psc_q == PSC_W'(CLK_PER_US - 1));
        width_sat  = (width_q == {XVAL_W{1'b1}});
        // Include the current cycle's tick so N*CLK_PER_US high cycles measure N.
        width_meas = width_q;
        if (state_q == StHigh && us_tick && !width_sat) begin
            width_meas = width_q + XVAL_W'(1);
        end
        period_hit = us_tick && (32'(period_q) == TIMEOUT_US - 1);
        // A saturated count means the true width is unknown, so it is never accepted.
        in_range   = (32'(width_meas) >= MIN_US) && (32'(width_meas) <= MAX_US) &&
                     (width_meas != {XVAL_W{1'b1}});
    end

    always_comb begin
        state_d   = state_q;
        psc_d     = us_tick ? '0 : psc_q + PSC_W'(1);
        width_d   = width_meas;
        period_d  = us_tick ? period_q + PERIOD_W'(1) : period_q;
        x_val_d   = x_val_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        timeout_d = timeout_q;

        if (rise) begin
            state_d  = StHigh;
            psc_d    = '0;
            width_d  = '0;
            period_d = '0;
        end else if (period_hit) begin
            state_d   = StIdle;
            psc_d     = '0;
            width_d   = '0;
            period_d  = '0;
            x_val_d   = XVAL_W'(NEUTRAL_US);
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                StHigh: begin
                    if (fall) begin
                        state_d = StLow;
                        if (in_range) begin
                            x_val_d   = width_meas;
                            valid_d   = 1'b1;
                            timeout_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            psc_q     <= '0;
            width_q   <= '0;
            period_q  <= '0;
            x_val_q   <= XVAL_W'(NEUTRAL_US);
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_q     <= psc_d;
            width_q   <= width_d;
            period_q  <= period_d;
            x_val_q   <= x_val_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign x_val   = x_val_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign timeout = timeout_q;

    logic unused_level;
    assign unused_level = line_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a shortened time base (2 clk per us,
// 3000 us timeout) so every scenario fits a short simulation.
module tb_pwm_capture;

    localparam int unsigned US      = 2;
    localparam int unsigned TIMEOUT = 3000;

    logic        clk;
    logic        rst;
    logic        pwm_in;
    logic [10:0] x_val;
    logic        valid;
    logic        err;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    pwm_capture #(
        .CLK_PER_US (US),
        .MIN_US     (800),
        .MAX_US     (2200),
        .TIMEOUT_US (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pwm_in  (pwm_in),
        .x_val   (x_val),
        .valid   (valid),
        .err     (err),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one pulse, then watch the low gap; lat is the first cycle after the
    // falling transition on which valid or err was seen.
    task automatic pulse(input int high_us, input int gap_us,
                         output int nv, output int ne, output int lat);
        nv  = 0;
        ne  = 0;
        lat = 0;
        pwm_in = 1'b1;
        cyc(high_us * US);
        pwm_in = 1'b0;
        for (int i = 1; i <= gap_us * US; i++) begin
            cyc(1);
            if (valid === 1'b1) begin
                nv++;
                if (lat == 0) lat = i;
            end
            if (err === 1'b1) begin
                ne++;
                if (lat == 0) lat = i;
            end
        end
    endtask

    int nv, ne, lat;

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        cyc(4);
        check("reset_x_val", int'(x_val), 1500);
        check("reset_valid", int'(valid), 0);
        check("reset_err", int'(err), 0);
        check("reset_timeout", int'(timeout), 0);
        rst = 1'b0;
        cyc(2);

        pulse(1500, 400, nv, ne, lat);
        check("p1500_valid_cnt", nv, 1);
        check("p1500_err_cnt", ne, 0);
        check("p1500_x_val", int'(x_val), 1500);
        check("p1500_timeout", int'(timeout), 0);

        pulse(1530, 400, nv, ne, lat);
        check("p1530_valid_cnt", nv, 1);
        check("p1530_latency", lat, 4);
        check("p1530_x_val", int'(x_val), 1530);

        pulse(1470, 400, nv, ne, lat);
        check("p1470_valid_cnt", nv, 1);
        check("p1470_latency", lat, 4);
        check("p1470_x_val", int'(x_val), 1470);

        pulse(1500, 400, nv, ne, lat);
        check("p1500b_x_val", int'(x_val), 1500);

        pulse(600, 400, nv, ne, lat);
        check("p600_err_cnt", ne, 1);
        check("p600_valid_cnt", nv, 0);
        check("p600_err_latency", lat, 4);
        check("p600_x_val", int'(x_val), 1500);

        pulse(2300, 400, nv, ne, lat);
        check("p2300_err_cnt", ne, 1);
        check("p2300_valid_cnt", nv, 0);
        check("p2300_x_val", int'(x_val), 1500);

        pulse(1700, 400, nv, ne, lat);
        check("p1700_valid_cnt", nv, 1);
        check("p1700_x_val", int'(x_val), 1700);
        check("p1700_timeout", int'(timeout), 0);
        cyc(TIMEOUT * US);
        check("lost_low_timeout", int'(timeout), 1);
        check("lost_low_x_val", int'(x_val), 1500);

        pulse(1600, 400, nv, ne, lat);
        check("p1600_valid_cnt", nv, 1);
        check("p1600_x_val", int'(x_val), 1600);
        check("p1600_timeout_clr", int'(timeout), 0);

        // Line stuck high: rise strobe lands 3 cycles after the drive, timeout
        // TIMEOUT us after that.
        pwm_in = 1'b1;
        cyc(TIMEOUT * US - 10);
        check("stuck_pre_timeout", int'(timeout), 0);
        cyc(30);
        check("stuck_timeout", int'(timeout), 1);
        check("stuck_x_val", int'(x_val), 1500);
        cyc(4000 * US - (TIMEOUT * US + 20));
        pwm_in = 1'b0;
        nv = 0;
        ne = 0;
        for (int i = 0; i < 400 * US; i++) begin
            cyc(1);
            if (valid === 1'b1) nv++;
            if (err === 1'b1) ne++;
        end
        check("stuck_fall_valid_cnt", nv, 0);
        check("stuck_fall_err_cnt", ne, 0);

        // Reset 500 us into a pulse, released with the line still high.
        pwm_in = 1'b1;
        cyc(500 * US);
        rst = 1'b1;
        cyc(4);
        rst = 1'b0;
        cyc(1500 * US - 500 * US - 4);
        pwm_in = 1'b0;
        nv = 0;
        ne = 0;
        for (int i = 0; i < 400 * US; i++) begin
            cyc(1);
            if (valid === 1'b1) nv++;
            if (err === 1'b1) ne++;
        end
        check("rstmid_valid_cnt", nv, 0);
        check("rstmid_err_cnt", ne, 0);
        check("rstmid_timeout", int'(timeout), 0);
        check("rstmid_x_val", int'(x_val), 1500);

        pulse(1200, 400, nv, ne, lat);
        check("p1200_valid_cnt", nv, 1);
        check("p1200_latency", lat, 4);
        check("p1200_x_val", int'(x_val), 1200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
